bt656_ast_rx: RTL and testbench

BT656_AST_RX -- requirements
Module: bt656_ast_rx

---
 rtl/bt656_pkg.sv | 35 +++
 rtl/bt656_ast_rx_if.sv | 30 +++
 rtl/bt656_ast_fifo.sv | 51 +++++
 rtl/bt656_ast_rx.sv | 192 +++++++++++++++++++
 tb/tb_bt656_ast_rx.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bt656_pkg.sv
// BT.656 receiver shared types: TRS flags, parser states, FIFO entry.
// Holds the TRS byte constants and the XY protection-bit function.
package bt656_pkg;

  typedef struct packed {
    logic f;
    logic v;
    logic h;
  } trs_t;

  typedef enum logic [2:0] {
    SEEK,
    Z1,
    Z2,
    XY,
    ACTIVE,
    DROP
  } state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    logic        field;
  } ast_word_t;

  localparam logic [7:0] TRS_FF = 8'hFF;
  localparam logic [7:0] TRS_00 = 8'h00;

  function automatic logic [3:0] prot_bits(trs_t t);
    return {t.v ^ t.h, t.f ^ t.h,
            t.f ^ t.v, t.f ^ t.v ^ t.h};
  endfunction

endpackage

// File: rtl/bt656_ast_rx_if.sv
// Avalon-ST source bundle for the BT.656 receiver.
// master drives data/valid/sop/eop/field, slave drives ready.
interface bt656_ast_rx_if;

  logic [15:0] aso_data;
  logic        aso_valid;
  logic        aso_ready;
  logic        aso_sop;
  logic        aso_eop;
  logic        aso_field;

  modport master (
    output aso_data,
    output aso_valid,
    output aso_sop,
    output aso_eop,
    output aso_field,
    input  aso_ready
  );

  modport slave (
    input  aso_data,
    input  aso_valid,
    input  aso_sop,
    input  aso_eop,
    input  aso_field,
    output aso_ready
  );

endinterface

// File: rtl/bt656_ast_fifo.sv
// Synchronous FIFO of ast_word_t (19 bits), DEPTH entries.
// Ports: clock, reset_n, push/wdata, pop/rdata, full, empty.
module bt656_ast_fifo
  import bt656_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  ast_word_t wdata,
  input  logic      pop,
  output ast_word_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  ast_word_t      mem [DEPTH];
  logic [AW:0]    wp;
  logic [AW:0]    rp;
  logic           do_pop;
  logic           do_push;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Gated so outputs read as zero while empty
  // (including straight out of reset).
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/bt656_ast_rx.sv
// BT.656 byte stream to Avalon-ST 16-bit {C,Y} packets, one per line.
// Ports: clock, reset_n, data in; aso (master) out; sync_ok,
// overflow, line_err status. Optional BT656_PROT_CHECK_EN checks
// the XY protection bits.
module bt656_ast_rx
  import bt656_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_WORDS  = 720
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  bt656_ast_rx_if.master        aso,
  output logic                  sync_ok,
  output logic                  overflow,
  output logic                  line_err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  state_t        state, state_nx;
  logic [7:0]    byte_in;
  trs_t          trs;
  logic          is_ff;
  logic          prot_bad;
  logic          trs_ok;
  logic          is_sav;

  logic          f_lat;
  logic          odd;
  logic [7:0]    chroma_q;
  ast_word_t     hold_q;
  logic          hold_v;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          term_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          full_eff;
  ast_word_t     wdata;
  ast_word_t     rdata;

  logic          word_done;
  logic          at_max;
  logic          eav_end;
  logic          flush;
  logic          want_data;
  logic          term_push;
  logic          push;
  logic          ovf_evt;
  logic          lerr_nx;

  assign byte_in = data[DATA_WIDTH-1 -: 8];
  assign trs     = byte_in[6:4];
  assign is_ff   = (byte_in == TRS_FF);

`ifdef BT656_PROT_CHECK_EN
  assign prot_bad = (byte_in[3:0] != prot_bits(trs));
`else
  assign prot_bad = 1'b0;
`endif

  assign trs_ok  = byte_in[7] && !prot_bad;
  assign is_sav  = trs_ok && !trs.h && !trs.v;
  assign cnt_inc = cnt + CW'(1);

  assign pop      = aso.aso_valid && aso.aso_ready;
  assign full_eff = fifo_full && !pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SEEK;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SEEK:   if (is_ff) state_nx = Z1;
      Z1:     state_nx = (byte_in == TRS_00) ? Z2 : SEEK;
      Z2:     state_nx = (byte_in == TRS_00) ? XY : SEEK;
      XY: begin
        if (is_sav) state_nx = term_q ? DROP : ACTIVE;
        else        state_nx = SEEK;
      end
      ACTIVE: begin
        if (is_ff)                 state_nx = Z1;
        else if (ovf_evt || at_max) state_nx = DROP;
      end
      DROP:   if (is_ff) state_nx = Z1;
      default: state_nx = SEEK;
    endcase
  end

  always_comb begin
    word_done = (state == ACTIVE) && !is_ff && odd;
    at_max    = word_done && (cnt_inc == CW'(MAX_WORDS));
    eav_end   = (state == ACTIVE) && is_ff;
    // A held word is closed out at EAV, or on the first DROP
    // cycle after the line hit MAX_WORDS.
    flush     = hold_v && (eav_end || (state == DROP));
    want_data = !term_q && ((word_done && hold_v) || flush);
    term_push = term_q && !full_eff;
    ovf_evt   = want_data && full_eff;
    push      = term_push || (want_data && !full_eff);
    if (term_q) begin
      wdata = '{data: 16'h0, sop: 1'b0,
                eop: 1'b1, field: f_lat};
    end else begin
      wdata = '{data: hold_q.data, sop: hold_q.sop,
                eop: flush, field: hold_q.field};
    end
    lerr_nx = (eav_end && (odd || (cnt == '0))) ||
              at_max ||
              ((state == XY) && byte_in[7] && prot_bad);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      f_lat    <= 1'b0;
      odd      <= 1'b0;
      chroma_q <= '0;
      hold_q   <= '0;
      hold_v   <= 1'b0;
      cnt      <= '0;
      term_q   <= 1'b0;
      sync_ok  <= 1'b0;
      overflow <= 1'b0;
      line_err <= 1'b0;
    end else begin
      line_err <= lerr_nx;
      if (state == XY) begin
        sync_ok <= trs_ok;
        if (is_sav && !term_q) begin
          f_lat  <= trs.f;
          odd    <= 1'b0;
          cnt    <= '0;
          hold_v <= 1'b0;
        end
      end
      if (state == ACTIVE) begin
        if (is_ff) begin
          odd    <= 1'b0;
          cnt    <= '0;
          hold_v <= 1'b0;
        end else if (!odd) begin
          chroma_q <= byte_in;
          odd      <= 1'b1;
        end else begin
          odd    <= 1'b0;
          cnt    <= cnt_inc;
          hold_v <= 1'b1;
          hold_q <= '{data: {chroma_q, byte_in},
                      sop: (cnt == '0),
                      eop: 1'b0, field: f_lat};
        end
      end
      if (state == DROP && flush) hold_v <= 1'b0;
      // Overflow abandons the rest of the line.
      if (ovf_evt) begin
        hold_v   <= 1'b0;
        term_q   <= 1'b1;
        overflow <= 1'b1;
      end else if (term_push) begin
        term_q <= 1'b0;
      end
    end
  end

  bt656_ast_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop),
    .rdata   (rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign aso.aso_valid = !fifo_empty;
  assign aso.aso_data  = rdata.data;
  assign aso.aso_sop   = rdata.sop;
  assign aso.aso_eop   = rdata.eop;
  assign aso.aso_field = rdata.field;

endmodule

// File: tb/tb_bt656_ast_rx.sv
// Directed bench for bt656_ast_rx: reset, full line, blanking,
// odd/empty lines, backpressure/overflow, protection bits, mid-line reset.
module tb_bt656_ast_rx;
  import bt656_pkg::*;

  logic       clock;
  logic       reset_n;
  logic [7:0] data;
  logic       sync_ok;
  logic       overflow;
  logic       line_err;

  bt656_ast_rx_if aso_if ();

  bt656_ast_rx dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .data     (data),
    .aso      (aso_if),
    .sync_ok  (sync_ok),
    .overflow (overflow),
    .line_err (line_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  ast_word_t q[$];
  int        lerr_cnt = 0;

  always @(negedge clock) begin
    if (reset_n && aso_if.aso_valid && aso_if.aso_ready)
      q.push_back('{data: aso_if.aso_data, sop: aso_if.aso_sop,
                    eop: aso_if.aso_eop, field: aso_if.aso_field});
    if (line_err) lerr_cnt++;
  end

  function automatic ast_word_t get(int idx);
    if (idx < q.size()) return q[idx];
    return '1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    data = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_trs(input logic [7:0] xy);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(xy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_byte(8'h10);
  endtask

  task automatic send_line(input logic [7:0] sav, input int pairs,
                           input logic [7:0] c, input logic [7:0] y);
    send_trs(sav);
    for (int i = 0; i < pairs; i++) begin
      send_byte(c);
      send_byte(y);
    end
    send_trs(8'h9D);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    data = 8'h00;
    aso_if.aso_ready = 1'b1;
    #3;
    n_checks++;
    if (aso_if.aso_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got %b want 0", aso_if.aso_valid);
    end
    n_checks++;
    if (sync_ok !== 1'b0) begin
      n_err++; $display("FAIL reset_sync got %b want 0", sync_ok);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf got %b want 0", overflow);
    end
    n_checks++;
    if (line_err !== 1'b0) begin
      n_err++; $display("FAIL reset_lerr got %b want 0", line_err);
    end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_normal;
    int base = q.size();
    int lb = lerr_cnt;
    int bad = 0;
    int sops = 0;
    int eops = 0;
    send_line(8'h80, 720, 8'h80, 8'h10);
    idle(4);
    n_checks++;
    if (q.size() - base !== 720) begin
      n_err++; $display("FAIL normal_count got %0d want 720", q.size() - base);
    end
    for (int i = base; i < q.size(); i++) begin
      if (q[i].data !== 16'h8010 || q[i].field !== 1'b0) bad++;
      if (q[i].sop) sops++;
      if (q[i].eop) eops++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_err++; $display("FAIL normal_data got %0d bad words want 0", bad);
    end
    n_checks++;
    if (get(base).sop !== 1'b1 || sops !== 1) begin
      n_err++; $display("FAIL normal_sop got first=%b n=%0d want 1/1", get(base).sop, sops);
    end
    n_checks++;
    if (get(base + 719).eop !== 1'b1 || eops !== 1) begin
      n_err++; $display("FAIL normal_eop got last=%b n=%0d want 1/1", get(base + 719).eop, eops);
    end
    n_checks++;
    if (sync_ok !== 1'b1) begin
      n_err++; $display("FAIL normal_sync got %b want 1", sync_ok);
    end
    n_checks++;
    if (lerr_cnt - lb !== 1) begin
      n_err++; $display("FAIL normal_maxwords_lerr got %0d want 1", lerr_cnt - lb);
    end
  endtask

  task automatic test_blanking;
    int base = q.size();
    int lb = lerr_cnt;
    send_line(8'hAB, 720, 8'h80, 8'h10);
    idle(4);
    n_checks++;
    if (q.size() - base !== 0) begin
      n_err++; $display("FAIL blank_count got %0d want 0", q.size() - base);
    end
    n_checks++;
    if (lerr_cnt - lb !== 0) begin
      n_err++; $display("FAIL blank_lerr got %0d want 0", lerr_cnt - lb);
    end
  endtask

  task automatic test_odd_line;
    int base = q.size();
    int lb = lerr_cnt;
    send_trs(8'h80);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    n_checks++;
    if (aso_if.aso_valid !== 1'b0) begin
      n_err++; $display("FAIL odd_early_valid got %b want 0", aso_if.aso_valid);
    end
    send_byte(8'h44);
    n_checks++;
    if (aso_if.aso_valid !== 1'b1 || aso_if.aso_data !== 16'h1122 || aso_if.aso_sop !== 1'b1) begin
      n_err++; $display("FAIL odd_latency got v=%b d=%h s=%b want 1/1122/1",
                        aso_if.aso_valid, aso_if.aso_data, aso_if.aso_sop);
    end
    send_byte(8'h55);
    send_trs(8'h9D);
    idle(4);
    n_checks++;
    if (q.size() - base !== 2) begin
      n_err++; $display("FAIL odd_count got %0d want 2", q.size() - base);
    end
    n_checks++;
    if (get(base) !== 19'({16'h1122, 1'b1, 1'b0, 1'b0})) begin
      n_err++; $display("FAIL odd_w0 got %h want %h", get(base), 19'({16'h1122, 3'b100}));
    end
    n_checks++;
    if (get(base + 1) !== 19'({16'h3344, 1'b0, 1'b1, 1'b0})) begin
      n_err++; $display("FAIL odd_w1 got %h want %h", get(base + 1), 19'({16'h3344, 3'b010}));
    end
    n_checks++;
    if (lerr_cnt - lb !== 1) begin
      n_err++; $display("FAIL odd_lerr got %0d want 1", lerr_cnt - lb);
    end
  endtask

  task automatic test_empty_line;
    int base = q.size();
    int lb = lerr_cnt;
    send_trs(8'h80);
    send_trs(8'h9D);
    idle(4);
    n_checks++;
    if (q.size() - base !== 0) begin
      n_err++; $display("FAIL empty_count got %0d want 0", q.size() - base);
    end
    n_checks++;
    if (lerr_cnt - lb !== 1) begin
      n_err++; $display("FAIL empty_lerr got %0d want 1", lerr_cnt - lb);
    end
  endtask

  task automatic test_back_to_back;
    int base = q.size();
    int lb = lerr_cnt;
    send_trs(8'hC7);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    send_trs(8'hDA);
    send_trs(8'h80);
    send_byte(8'h01);
    send_byte(8'h02);
    send_trs(8'h9D);
    idle(4);
    n_checks++;
    if (q.size() - base !== 3) begin
      n_err++; $display("FAIL b2b_count got %0d want 3", q.size() - base);
    end
    n_checks++;
    if (get(base) !== 19'({16'hA1B2, 3'b101})) begin
      n_err++; $display("FAIL b2b_w0 got %h want %h", get(base), 19'({16'hA1B2, 3'b101}));
    end
    n_checks++;
    if (get(base + 1) !== 19'({16'hC3D4, 3'b011})) begin
      n_err++; $display("FAIL b2b_w1 got %h want %h", get(base + 1), 19'({16'hC3D4, 3'b011}));
    end
    n_checks++;
    if (get(base + 2) !== 19'({16'h0102, 3'b110})) begin
      n_err++; $display("FAIL b2b_single got %h want %h", get(base + 2), 19'({16'h0102, 3'b110}));
    end
    n_checks++;
    if (lerr_cnt - lb !== 0) begin
      n_err++; $display("FAIL b2b_lerr got %0d want 0", lerr_cnt - lb);
    end
  endtask

  task automatic test_backpressure;
    int base = q.size();
    int lb = lerr_cnt;
    int bad = 0;
    aso_if.aso_ready = 1'b0;
    send_line(8'h80, 720, 8'h80, 8'h10);
    idle(2);
    n_checks++;
    if (aso_if.aso_valid !== 1'b1 || overflow !== 1'b1) begin
      n_err++; $display("FAIL bp_stall got v=%b ovf=%b want 1/1", aso_if.aso_valid, overflow);
    end
    n_checks++;
    if (lerr_cnt - lb !== 0) begin
      n_err++; $display("FAIL bp_lerr got %0d want 0", lerr_cnt - lb);
    end
    aso_if.aso_ready = 1'b1;
    idle(25);
    n_checks++;
    if (q.size() - base !== 17) begin
      n_err++; $display("FAIL bp_count got %0d want 17", q.size() - base);
    end
    for (int i = 0; i < 16; i++) begin
      if (get(base + i) !== 19'({16'h8010, (i == 0), 2'b00})) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_err++; $display("FAIL bp_words got %0d bad want 0", bad);
    end
    n_checks++;
    if (get(base + 16) !== 19'({16'h0000, 3'b010})) begin
      n_err++; $display("FAIL bp_term got %h want %h", get(base + 16), 19'({16'h0, 3'b010}));
    end
    n_checks++;
    if (aso_if.aso_valid !== 1'b0 || sync_ok !== 1'b1) begin
      n_err++; $display("FAIL bp_after got v=%b sync=%b want 0/1", aso_if.aso_valid, sync_ok);
    end
  endtask

  task automatic test_prot_check;
    int base = q.size();
    int lb = lerr_cnt;
    logic exp_sync;
    int exp_words;
    int exp_lerr;
`ifdef BT656_PROT_CHECK_EN
    exp_sync = 1'b0;
    exp_words = 0;
    exp_lerr = 2;
`else
    exp_sync = 1'b1;
    exp_words = 2;
    exp_lerr = 0;
`endif
    send_trs(8'h90);
    n_checks++;
    if (sync_ok !== exp_sync) begin
      n_err++; $display("FAIL prot_90_sync got %b want %b", sync_ok, exp_sync);
    end
    idle(6);
    send_trs(8'h81);
    n_checks++;
    if (sync_ok !== exp_sync) begin
      n_err++; $display("FAIL prot_81_sync got %b want %b", sync_ok, exp_sync);
    end
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    send_trs(8'h9D);
    idle(4);
    n_checks++;
    if (q.size() - base !== exp_words) begin
      n_err++; $display("FAIL prot_words got %0d want %0d", q.size() - base, exp_words);
    end
    n_checks++;
    if (lerr_cnt - lb !== exp_lerr) begin
      n_err++; $display("FAIL prot_lerr got %0d want %0d", lerr_cnt - lb, exp_lerr);
    end
  endtask

  task automatic test_reset_midline;
    int base;
    aso_if.aso_ready = 1'b0;
    send_trs(8'h80);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h12);
      send_byte(8'h34);
    end
    n_checks++;
    if (aso_if.aso_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_pre_valid got %b want 1", aso_if.aso_valid);
    end
    base = q.size();
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (aso_if.aso_valid !== 1'b0 || sync_ok !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got v=%b sync=%b ovf=%b want 0/0/0",
                        aso_if.aso_valid, sync_ok, overflow);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    aso_if.aso_ready = 1'b1;
    send_byte(8'h12);
    send_trs(8'h9D);
    idle(4);
    n_checks++;
    if (q.size() - base !== 0) begin
      n_err++; $display("FAIL mid_discard got %0d words want 0", q.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_blanking();
    test_odd_line();
    test_empty_line();
    test_back_to_back();
    test_backpressure();
    test_prot_check();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
